mem_wb_pipe: RTL and testbench

Parametrised MEM/WB pipeline register for the multi-issue core. It carries up to LANES write-back bundles from the memory-access stage to the register-file write port. It implements the standard stall-vector protocol: bubble, advance or hold. On top of that it adds flush, per-lane valid, x0 write suppression, intra-bundle same-destination resolution, and a retired-instruction counter feeding the CSR block.

---
 rtl/mem_wb_pipe_pkg.sv | 23 ++
 rtl/wb_dest_kill.sv | 26 ++
 rtl/mem_wb_pipe.sv | 121 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and types for the MEM/WB pipeline register and its helpers.
package mem_wb_pipe_pkg;

    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  Reg0addr     = 5'd0;

    typedef enum logic [1:0] {
        ActHold    = 2'd0,
        ActBubble  = 2'd1,
        ActAdvance = 2'd2
    } stage_action_e;

    // Bits needed to hold a popcount of 'lanes' valid flags.
    function automatic int popWidth(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/wb_dest_kill.sv
// Marks older lanes whose register write is overwritten by a younger lane of the same bundle.
module wb_dest_kill
    import mem_wb_pipe_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int REG_AW = 5
) (
    input  logic [LANES-1:0]        valid_i,
    input  logic [LANES-1:0]        wreg_i,
    input  logic [LANES*REG_AW-1:0] rd_addr_i,
    output logic [LANES-1:0]        kill_o
);

    always_comb begin
        kill_o = '0;
        for (int n = 0; n < LANES; n++) begin
            for (int m = n + 1; m < LANES; m++) begin
                if (valid_i[m] && (wreg_i[m] == WriteEnable) &&
                    (rd_addr_i[m*REG_AW +: REG_AW] == rd_addr_i[n*REG_AW +: REG_AW])) begin
                    kill_o[n] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: bubble/advance/hold on the stall vector, flush, x0 and
// same-destination write suppression, plus the retired-instruction counter.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        mem_valid_i,
    input  logic [LANES-1:0]        mem_wreg_i,
    input  logic [LANES*REG_AW-1:0] mem_rd_addr_i,
    input  logic [LANES*XLEN-1:0]   mem_rd_data_i,
    output logic [LANES-1:0]        wb_valid_o,
    output logic [LANES-1:0]        wb_wreg_o,
    output logic [LANES*REG_AW-1:0] wb_rd_addr_o,
    output logic [LANES*XLEN-1:0]   wb_rd_data_o,
    output logic [CNT_W-1:0]        retire_cnt_o
);

    localparam int PopW = popWidth(LANES);

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES-1:0]        wreg_q, wreg_d;
    logic [LANES*REG_AW-1:0] addr_q, addr_d;
    logic [LANES*XLEN-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LANES-1:0]        kill;
    logic [PopW-1:0]         popCnt;
    stage_action_e           action;
    logic                    unusedStall;

    // Only the MEM and WB bits matter here; the rest of the vector is folded away.
    assign unusedStall = ^stall;

    wb_dest_kill #(
        .LANES  (LANES),
        .REG_AW (REG_AW)
    ) u_dest_kill (
        .valid_i   (mem_valid_i),
        .wreg_i    (mem_wreg_i),
        .rd_addr_i (mem_rd_addr_i),
        .kill_o    (kill)
    );

    // Flush beats the stall vector; a stopped MEM with a running WB injects a bubble.
    always_comb begin
        if (flush) begin
            action = ActBubble;
        end else if (stall[STAGE_IDX] == NoStop) begin
            action = ActAdvance;
        end else if (stall[STAGE_IDX+1] == Stop) begin
            action = ActHold;
        end else begin
            action = ActBubble;
        end
    end

    always_comb begin
        valid_d = valid_q;
        wreg_d  = wreg_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        popCnt  = '0;
        for (int n = 0; n < LANES; n++) begin
            popCnt = popCnt + PopW'(mem_valid_i[n]);
        end
        case (action)
            ActBubble: begin
                valid_d = '0;
                wreg_d  = {LANES{WriteDisable}};
                addr_d  = '0;
                data_d  = {LANES{XLEN'(ZeroWord)}};
            end
            ActAdvance: begin
                valid_d = mem_valid_i;
                addr_d  = mem_rd_addr_i;
                data_d  = mem_rd_data_i;
                for (int n = 0; n < LANES; n++) begin
                    wreg_d[n] = (mem_valid_i[n] && mem_wreg_i[n] && !kill[n] &&
                                 (mem_rd_addr_i[n*REG_AW +: REG_AW] != REG_AW'(Reg0addr)))
                                ? WriteEnable : WriteDisable;
                end
                // Retirement counts every valid lane, even x0 and killed writes.
                cnt_d = cnt_q + CNT_W'(popCnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
            wreg_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid_o   = valid_q;
    assign wb_wreg_o    = wreg_q;
    assign wb_rd_addr_o = addr_q;
    assign wb_rd_data_o = data_q;
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe with two lanes and a 4-bit retire counter.
module tb_mem_wb_pipe;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  w;
        logic [9:0]  a;
        logic [63:0] d;
        logic [3:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  memValid;
    logic [1:0]  memWreg;
    logic [9:0]  memAddr;
    logic [63:0] memData;
    logic [1:0]  wbValid;
    logic [1:0]  wbWreg;
    logic [9:0]  wbAddr;
    logic [63:0] wbData;
    logic [3:0]  retireCnt;

    exp_t  expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    mem_wb_pipe #(
        .LANES     (2),
        .XLEN      (32),
        .REG_AW    (5),
        .STALL_W   (6),
        .STAGE_IDX (4),
        .CNT_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .mem_valid_i   (memValid),
        .mem_wreg_i    (memWreg),
        .mem_rd_addr_i (memAddr),
        .mem_rd_data_i (memData),
        .wb_valid_o    (wbValid),
        .wb_wreg_o     (wbWreg),
        .wb_rd_addr_o  (wbAddr),
        .wb_rd_data_o  (wbData),
        .retire_cnt_o  (retireCnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs after a falling edge and queue the outputs expected after the next rise.
    task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s,
                                 input logic [1:0] v, input logic [1:0] w,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [1:0] ev, input logic [1:0] ew,
                                 input logic [4:0] ea0, input logic [4:0] ea1,
                                 input logic [31:0] ed0, input logic [31:0] ed1,
                                 input logic [3:0] ec, input string nm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        flush    = f;
        stall    = s;
        memValid = v;
        memWreg  = w;
        memAddr  = {a1, a0};
        memData  = {d1, d0};
        e.v = ev;
        e.w = ew;
        e.a = {ea1, ea0};
        e.d = {ed1, ed0};
        e.c = ec;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clk);
    endtask

    task automatic checkOutput(input exp_t e, input string nm);
        checks += 5;
        if (wbValid !== e.v) begin
            errors++;
            $display("[TB] FAIL %s valid: got %b want %b", nm, wbValid, e.v);
        end
        if (wbWreg !== e.w) begin
            errors++;
            $display("[TB] FAIL %s wreg: got %b want %b", nm, wbWreg, e.w);
        end
        if (wbAddr !== e.a) begin
            errors++;
            $display("[TB] FAIL %s addr: got %h want %h", nm, wbAddr, e.a);
        end
        if (wbData !== e.d) begin
            errors++;
            $display("[TB] FAIL %s data: got %h want %h", nm, wbData, e.d);
        end
        if (retireCnt !== e.c) begin
            errors++;
            $display("[TB] FAIL %s count: got %0d want %0d", nm, retireCnt, e.c);
        end
    endtask

    // Monitor: every falling edge, compare the registered outputs against the oldest expectation.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                checkOutput(e, nm);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0;
        memValid = '0; memWreg = '0; memAddr = '0; memData = '0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'($urandom), 6'($urandom), 2'($urandom), 2'($urandom),
                          5'($urandom), 5'($urandom), $urandom, $urandom,
                          2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0, "reset");
        end
        applyStimulus(0, 0, 6'b000000, 2'b01, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                      2'b01, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 4'd1, "first_advance");

        // Stall protocol: bubble, hold, advance
        applyStimulus(0, 0, 6'b010000, 2'b01, 2'b01, 5'd9, 5'd0, 32'h1111, 32'h0,
                      2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd1, "bubble");
        applyStimulus(0, 0, 6'b000000, 2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44,
                      2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 4'd3, "two_lane_advance");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 6'b110000, 2'b11, 2'b11, 5'd8, 5'd8, 32'h88, 32'h99,
                          2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 4'd3, "hold");
        end
        applyStimulus(0, 0, 6'b000000, 2'b01, 2'b11, 5'd6, 5'd6, 32'h66, 32'h77,
                      2'b01, 2'b01, 5'd6, 5'd6, 32'h66, 32'h77, 4'd4, "invalid_younger_no_kill");

        // x0 suppression and flush
        applyStimulus(0, 0, 6'b000000, 2'b01, 2'b01, 5'd0, 5'd0, 32'h1234, 32'h0,
                      2'b01, 2'b00, 5'd0, 5'd0, 32'h1234, 32'h0, 4'd5, "x0_write");
        applyStimulus(0, 1, 6'b000000, 2'b11, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22,
                      2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd5, "flush");

        // Same-destination kill: youngest writer wins
        applyStimulus(0, 0, 6'b000000, 2'b11, 2'b11, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB,
                      2'b11, 2'b10, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB, 4'd7, "same_dest_kill");
        applyStimulus(0, 0, 6'b000000, 2'b11, 2'b01, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB,
                      2'b11, 2'b01, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB, 4'd9, "younger_no_wreg");

        // Counter wrap: climb from 9 to 14, then +2 wraps to 0, then +1
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 6'b000000, 2'b01, 2'b01, 5'(k + 1), 5'd0, 32'(k + 1), 32'h0,
                          2'b01, 2'b01, 5'(k + 1), 5'd0, 32'(k + 1), 32'h0, 4'(10 + k), "preload");
        end
        applyStimulus(0, 0, 6'b000000, 2'b11, 2'b11, 5'd10, 5'd11, 32'hA0, 32'hB0,
                      2'b11, 2'b11, 5'd10, 5'd11, 32'hA0, 32'hB0, 4'd0, "wrap");
        applyStimulus(0, 0, 6'b000000, 2'b01, 2'b01, 5'd12, 5'd0, 32'hC0, 32'h0,
                      2'b01, 2'b01, 5'd12, 5'd0, 32'hC0, 32'h0, 4'd1, "after_wrap");

        // Priority: reset over flush over hold, flush over hold
        applyStimulus(1, 1, 6'b110000, 2'b11, 2'b11, 5'd3, 5'd4, 32'h5, 32'h6,
                      2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0, "rst_over_flush");
        applyStimulus(0, 0, 6'b000000, 2'b01, 2'b01, 5'd2, 5'd0, 32'h22, 32'h0,
                      2'b01, 2'b01, 5'd2, 5'd0, 32'h22, 32'h0, 4'd1, "reload");
        applyStimulus(0, 1, 6'b110000, 2'b11, 2'b11, 5'd3, 5'd4, 32'h5, 32'h6,
                      2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd1, "flush_over_hold");
        applyStimulus(0, 0, 6'b110000, 2'b11, 2'b11, 5'd3, 5'd4, 32'h5, 32'h6,
                      2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd1, "hold_bubble");

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
